fifo_wr: RTL
============

# fifo_wr

Write-side pointer and flag controller for the dual-clock handshake FIFO, running entirely in the write clock domain. It accepts write requests, produces the binary write address and memory write enable, and maintains a registered gray-coded write pointer for synchronisation into the read domain. It generates a registered full flag from the synchronised gray read pointer, a sticky overflow flag, and optionally a fill level with an almost-full flag.

## Interface
- P_SIZE, 4, pointer width; address width P_SIZE-1; depth 2^(P_SIZE-1)
- AF_LEVEL, 6, fill level at or above which almost_full asserts (1..depth)
- w_clk  input  1  write-domain clock
- w_rst  input  1  write-domain reset, asynchronous, active-high
- w_inc  input  1  write request
- sync_rd_ptr  input  P_SIZE  gray read pointer, already synchronised into w_clk
- ovf_clr  input  1  clears the sticky overflow flag
- w_en  output  1  memory write enable, combinational: w_inc & ~full
- wr_addr  output  P_SIZE-1  binary write address, wr_ptr[P_SIZE-2:0]
- gray_wr_ptr  output  P_SIZE  registered gray write pointer
- full  output  1  registered FIFO-full flag
- ovf  output  1  sticky overflow flag
- wr_level  output  P_SIZE  registered fill level as seen by the writer
- almost_full  output  1  registered, wr_level >= AF_LEVEL

## Operation
- Internal binary pointer wr_ptr, P_SIZE bits. wr_ptr_next = wr_ptr + 1 when w_en, otherwise wr_ptr. Increment is modulo 2^P_SIZE.
- gray_next = wr_ptr_next ^ (wr_ptr_next >> 1). gray_wr_ptr <= gray_next, so gray_wr_ptr always equals gray(wr_ptr) with no extra lag.
- full <= (gray_next == {~sync_rd_ptr[P_SIZE-1:P_SIZE-2], sync_rd_ptr[P_SIZE-3:0]}). It is re-evaluated every cycle, with or without a write.
- Write while full (w_inc & full): nothing is written, w_en = 0, and the pointers hold. ovf sets on the next edge.
- ovf: set on w_inc & full; cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Level (feature-gated): rd_bin is the gray-to-binary conversion of sync_rd_ptr (XOR prefix from the MSB down). wr_level <= (wr_ptr_next - rd_bin) mod 2^P_SIZE. almost_full <= (that value >= AF_LEVEL).
- The level is pessimistic: reads become visible only after read-to-write synchronisation latency. It never exceeds the depth.
- Reset (w_rst high, asynchronous): wr_ptr = 0, gray_wr_ptr = 0, full = 0, ovf = 0, wr_level = 0, almost_full = 0. wr_addr = 0 and w_en = 0 while in reset.
- Reset mid-operation discards all pointer state immediately. No write is issued during reset, even with w_inc high.

## Timing
- w_en and wr_addr are valid in the same cycle as w_inc. Memory captures data at the w_clk edge where w_en = 1.
- A write that makes the FIFO full commits on edge N, and full = 1 from edge N. Back-to-back writes therefore never exceed the depth.
- A change on sync_rd_ptr that frees space deasserts full one edge later (registered).
- gray_wr_ptr changes exactly 1 bit per accepted write and is stable otherwise.
- wr_level and almost_full have the same one-edge latency as full.

## Configuration
- FIFO_WR_ALMOST_FULL_EN
  - Defined: the gray-to-binary converter, level subtractor and wr_level/almost_full registers are built.
  - Undefined: wr_level and almost_full are tied to 0 and no level logic is synthesised. full, ovf and the pointer behaviour are identical in both builds.

## Test plan
All scenarios use P_SIZE=4 and AF_LEVEL=6, with the macro defined unless noted.
- Reset: pulse w_rst asynchronously mid-cycle with w_inc=1 -> all outputs 0 immediately and w_en=0 throughout reset. After release, the first write goes to wr_addr=0.
- Fill: sync_rd_ptr=0, 8 consecutive w_inc -> wr_addr 0..7 with w_en=1 on each. full=1 from the 8th edge, gray_wr_ptr=4'b1100, wr_level=8, almost_full=1 from the 6th edge.
- Overflow:
  - 9th w_inc while full -> w_en=0, wr_addr stays 0, ovf=1 next edge.
  - ovf_clr=1 with w_inc=0 -> ovf=0.
  - ovf_clr=1 together with w_inc & full -> ovf stays 1.
- Release: from full, set sync_rd_ptr=4'b0001 -> full=0 one edge later, wr_level=7. The next write targets wr_addr=0, after which full=1 again.
- Wrap: 20 writes with sync_rd_ptr tracking gray(wr_ptr-2) -> full never asserts and wr_level stays 2. The pointer wraps from gray 4'b1000 to 4'b0000, and every gray step changes exactly 1 bit.
- Macro undefined: repeat the Fill scenario -> full and ovf behaviour identical; wr_level=0 and almost_full=0 throughout.

Source files
------------

// File: rtl/fifo_wr_if.sv
// Write-side handshake bundle between the FIFO writer and the write pointer/flag controller.
interface fifo_wr_if #(
  parameter int P_SIZE = 4
) ();
  logic              w_inc;
  logic [P_SIZE-1:0] sync_rd_ptr;
  logic              ovf_clr;
  logic              w_en;
  logic [P_SIZE-2:0] wr_addr;
  logic [P_SIZE-1:0] gray_wr_ptr;
  logic              full;
  logic              ovf;
  logic [P_SIZE-1:0] wr_level;
  logic              almost_full;

  modport master (
    output w_inc, sync_rd_ptr, ovf_clr,
    input  w_en, wr_addr, gray_wr_ptr, full, ovf, wr_level, almost_full
  );

  modport slave (
    input  w_inc, sync_rd_ptr, ovf_clr,
    output w_en, wr_addr, gray_wr_ptr, full, ovf, wr_level, almost_full
  );
endinterface

// File: rtl/fifo_wr.sv
// Write-domain pointer/flag controller of the dual-clock FIFO: binary address, gray pointer, full, overflow.
// Define FIFO_WR_ALMOST_FULL_EN to build the fill level and almost-full logic.
module fifo_wr #(
  parameter int P_SIZE   = 4,
  parameter int AF_LEVEL = 6
) (
  input logic      w_clk,
  input logic      w_rst,
  fifo_wr_if.slave bus
);
  logic [P_SIZE-1:0] wr_ptr_reg;
  logic [P_SIZE-1:0] wr_ptr_next;
  logic [P_SIZE-1:0] gray_reg;
  logic [P_SIZE-1:0] gray_next;
  logic [P_SIZE-1:0] full_match;
  logic              full_reg;
  logic              ovf_reg;

  // Reset also gates the enable so no write escapes while w_rst is high.
  assign bus.w_en        = bus.w_inc & ~full_reg & ~w_rst;
  assign bus.wr_addr     = wr_ptr_reg[P_SIZE-2:0];
  assign bus.gray_wr_ptr = gray_reg;
  assign bus.full        = full_reg;
  assign bus.ovf         = ovf_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (bus.w_en) begin
      wr_ptr_next = wr_ptr_reg + P_SIZE'(1);
    end
    gray_next  = wr_ptr_next ^ (wr_ptr_next >> 1);
    // Full when the writer is exactly one lap ahead: top two gray bits inverted.
    full_match = {~bus.sync_rd_ptr[P_SIZE-1:P_SIZE-2], bus.sync_rd_ptr[P_SIZE-3:0]};
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wr_ptr_reg <= '0;
      gray_reg   <= '0;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      gray_reg   <= gray_next;
      full_reg   <= (gray_next == full_match);
      if (bus.w_inc && full_reg) begin
        ovf_reg <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [P_SIZE-1:0] rd_bin;
  logic [P_SIZE-1:0] level_next;
  logic [P_SIZE-1:0] level_reg;
  logic              af_next;
  logic              af_reg;

  // Each binary bit is the XOR of all gray bits from the MSB down to it.
  generate
    for (genvar gi = 0; gi < P_SIZE; gi++) begin : g_g2b
      assign rd_bin[gi] = ^bus.sync_rd_ptr[P_SIZE-1:gi];
    end
  endgenerate

  assign level_next = wr_ptr_next - rd_bin;
  assign af_next    = (level_next >= P_SIZE'(AF_LEVEL));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      level_reg <= '0;
      af_reg    <= 1'b0;
    end else begin
      level_reg <= level_next;
      af_reg    <= af_next;
    end
  end

  assign bus.wr_level    = level_reg;
  assign bus.almost_full = af_reg;
`else
  assign bus.wr_level    = '0;
  assign bus.almost_full = 1'b0;
`endif

endmodule
